hack_cpu_ctrl: RTL and testbench

Multi-cycle Hack instruction sequencer: the control side of the 16-bit ALU, producing operands and `{zx,nx,zy,ny,f,no}` and consuming `out/zr/ng`. It fetches from instruction ROM, owns the A, D and PC registers, issues data-memory reads and writes, and evaluates jump conditions. It sits between the ROM/RAM responders and the ALU inside the CPU top level.

---
 rtl/hack_pkg.sv | 15 +
 rtl/hack_jump_cond.sv | 11 +
 rtl/hack_cpu_ctrl.sv | 75 +++++++
 tb/tb_hack_cpu_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// hack_pkg: sequencer states, Hack instruction field positions and datapath widths
package hack_pkg;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 15;
  localparam int A_BIT = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;
  localparam int J_LT = 2;
  localparam int J_EQ = 1;
  localparam int J_GT = 0;
  typedef enum logic [1:0] {FETCH, DECODE, READ, EXEC} state_t;
endpackage

// File: rtl/hack_jump_cond.sv
// hack_jump_cond: decides whether a C-instruction jump is taken from its jump bits and the ALU flags
module hack_jump_cond
  import hack_pkg::*;
(
  input  logic [2:0] jmp,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);
  assign take = (jmp[J_LT] & ng) | (jmp[J_EQ] & zr) | (jmp[J_GT] & ~ng & ~zr);
endmodule

// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: multi-cycle Hack sequencer owning A, D and PC, driving the external ALU and memories
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [WORD_W-1:0] instr_data,
  input  logic              instr_valid,
  output logic              mem_re,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] alu_x,
  output logic [WORD_W-1:0] alu_y,
  output logic [5:0]        alu_ctrl,
  input  logic [WORD_W-1:0] alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] pc,
  output logic [WORD_W-1:0] a_reg,
  output logic [WORD_W-1:0] d_reg
);
  state_t state, nxt;
  logic [WORD_W-1:0] ir, m;
  logic take;
  hack_jump_cond u_jump (
    .jmp (ir[J_LT:J_GT]),
    .zr  (alu_zr),
    .ng  (alu_ng),
    .take(take)
  );
  always_comb begin
    nxt = (state == FETCH)  ? (instr_valid ? DECODE : FETCH) :
          (state == DECODE) ? (!ir[WORD_W-1] ? FETCH : ir[A_BIT] ? READ : EXEC) :
          (state == READ)   ? (mem_rvalid ? EXEC : READ) : FETCH;
    instr_req = !reset && state == FETCH;
    mem_re = !reset && state == READ;
    mem_we = !reset && state == EXEC && ir[DEST_M];
  end
  assign instr_addr = pc;
  assign mem_addr = a_reg[ADDR_W-1:0];
  assign mem_wdata = alu_out;
  assign alu_x = d_reg;
  assign alu_y = ir[A_BIT] ? m : a_reg;
  assign alu_ctrl = ir[COMP_HI:COMP_LO];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc <= PC_RESET;
      a_reg <= '0;
      d_reg <= '0;
      ir <= '0;
      m <= '0;
    end else begin
      state <= nxt;
      if (state == FETCH && instr_valid) ir <= instr_data;
      if (state == READ && mem_rvalid) m <= mem_rdata;
      if (state == DECODE && !ir[WORD_W-1]) begin
        a_reg <= {1'b0, ir[ADDR_W-1:0]};
        pc <= pc + 1'b1;
      end
      if (state == EXEC) begin
        if (ir[DEST_A]) a_reg <= alu_out;
        if (ir[DEST_D]) d_reg <= alu_out;
        pc <= take ? a_reg[ADDR_W-1:0] : pc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb_hack_cpu_ctrl: table-driven check of the Hack sequencer with ROM/RAM responders and a reference ALU
module tb_hack_cpu_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic instr_req, instr_valid = 1'b0, mem_re, mem_rvalid = 1'b0, mem_we, alu_zr = 1'b0, alu_ng = 1'b0;
  logic [14:0] instr_addr, mem_addr, pc;
  logic [15:0] instr_data = '0, mem_rdata = '0, mem_wdata, alu_x, alu_y, alu_out = '0, a_reg, d_reg;
  logic [5:0] alu_ctrl;
  hack_cpu_ctrl dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_data(instr_data), .instr_valid(instr_valid),
    .mem_re(mem_re), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .pc(pc), .a_reg(a_reg), .d_reg(d_reg)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] p0, p1, p2, p3, m3;
    int rw, mw;
    logic [15:0] ea, ed;
    logic [14:0] epc;
    int ewr;
    logic [14:0] waddr;
    logic [15:0] wdata;
    int ecyc;
    logic [5:0] ectrl;
  } vec_t;
  vec_t v[12];
  logic [15:0] rom[32], ram[32];
  int rom_wait, mem_wait, rc, mc, checks, errors, fetches, wr_cnt;
  logic s_req, s_hs, s_re, s_we;
  logic [14:0] s_addr, s_pc, wr_addr, hs_addr;
  logic [15:0] s_a, s_d, wr_data;
  logic [5:0] s_ctrl, ex_ctrl;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    logic [15:0] x, y, o;
    @(negedge clk);
    if (instr_req) begin
      instr_valid = (rc >= rom_wait);
      rc = instr_valid ? 0 : rc + 1;
    end else begin
      instr_valid = 1'b0;
      rc = 0;
    end
    instr_data = rom[instr_addr[4:0]];
    if (mem_re) begin
      mem_rvalid = (mc >= mem_wait);
      mc = mem_rvalid ? 0 : mc + 1;
    end else begin
      mem_rvalid = 1'b0;
      mc = 0;
    end
    mem_rdata = ram[mem_addr[4:0]];
    x = alu_ctrl[5] ? 16'h0 : alu_x;
    x = alu_ctrl[4] ? ~x : x;
    y = alu_ctrl[3] ? 16'h0 : alu_y;
    y = alu_ctrl[2] ? ~y : y;
    o = alu_ctrl[1] ? x + y : x & y;
    o = alu_ctrl[0] ? ~o : o;
    alu_out = o;
    alu_zr = (o == 16'h0);
    alu_ng = o[15];
    #1;
    s_req = instr_req;
    s_hs = instr_req && instr_valid;
    s_addr = instr_addr;
    s_re = mem_re;
    s_we = mem_we;
    s_ctrl = alu_ctrl;
    s_pc = pc;
    s_a = a_reg;
    s_d = d_reg;
    if (mem_we) begin
      wr_cnt++;
      wr_addr = mem_addr;
      wr_data = mem_wdata;
      ram[mem_addr[4:0]] = mem_wdata;
    end
    @(posedge clk);
  endtask
  task automatic load(input logic [15:0] p0, p1, p2, p3, m3, input int rw, mw);
    for (int i = 0; i < 32; i++) begin
      rom[i] = '0;
      ram[i] = '0;
    end
    rom[0] = p0;
    rom[1] = p1;
    rom[2] = p2;
    rom[3] = p3;
    ram[3] = m3;
    rom_wait = rw;
    mem_wait = mw;
  endtask
  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    tick();
    chk({tag, "_rst_req"}, s_req, 0);
    chk({tag, "_rst_we"}, s_we, 0);
    chk({tag, "_rst_pc"}, s_pc, 0);
    reset = 1'b0;
    wr_cnt = 0;
  endtask
  task automatic run(input int n, output int cyc_o, output bit ok);
    int onset, t0;
    bit prev;
    onset = 0;
    t0 = 0;
    prev = 1'b0;
    ok = 1'b0;
    cyc_o = 0;
    fetches = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (s_req && !prev) begin
        if (fetches == n) begin
          cyc_o = k - t0;
          ok = 1'b1;
          break;
        end
        onset = k;
      end
      if (s_hs) begin
        fetches++;
        if (fetches == n) begin
          t0 = onset;
          wr_cnt = 0;
          hs_addr = s_addr;
        end
      end
      prev = s_req;
      ex_ctrl = s_ctrl;
    end
  endtask
  initial begin
    int cyc, n;
    bit ok;
    string t;
    checks = 0;
    errors = 0;
    rc = 0;
    mc = 0;
    wr_cnt = 0;
    v[0]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h0000, 0, 0, 16'h0005, 16'h0000, 15'h0004, 0, 15'h0, 16'h0, 2, 6'b000000};
    v[1]  = '{16'h0000, 16'h0000, 16'h0005, 16'hEC10, 16'h0000, 0, 0, 16'h0005, 16'h0005, 15'h0004, 0, 15'h0, 16'h0, 3, 6'b110000};
    v[2]  = '{16'h0000, 16'h0005, 16'hEC10, 16'hE7C8, 16'h0000, 0, 0, 16'h0005, 16'h0005, 15'h0004, 1, 15'h5, 16'h6, 3, 6'b011111};
    v[3]  = '{16'h0005, 16'hEC10, 16'h0010, 16'hE301, 16'h0000, 0, 0, 16'h0010, 16'h0005, 15'h0010, 0, 15'h0, 16'h0, 3, 6'b001100};
    v[4]  = '{16'h0000, 16'hEC10, 16'h0010, 16'hE301, 16'h0000, 0, 0, 16'h0010, 16'h0000, 15'h0004, 0, 15'h0, 16'h0, 3, 6'b001100};
    v[5]  = '{16'h0000, 16'hEE90, 16'h0010, 16'hE301, 16'h0000, 0, 0, 16'h0010, 16'hFFFF, 15'h0004, 0, 15'h0, 16'h0, 3, 6'b001100};
    v[6]  = '{16'h0000, 16'h0000, 16'h0010, 16'hEA87, 16'h0000, 0, 0, 16'h0010, 16'h0000, 15'h0010, 0, 15'h0, 16'h0, 3, 6'b101010};
    v[7]  = '{16'h0000, 16'h0000, 16'h0003, 16'hFCA8, 16'h0001, 0, 3, 16'h0000, 16'h0000, 15'h0004, 1, 15'h3, 16'h0, 7, 6'b110010};
    v[8]  = '{16'h0000, 16'h0000, 16'h0003, 16'hFC10, 16'h1234, 0, 0, 16'h0003, 16'h1234, 15'h0004, 0, 15'h0, 16'h0, 4, 6'b110000};
    v[9]  = '{16'h0000, 16'hEE90, 16'h0010, 16'hE304, 16'h0000, 0, 0, 16'h0010, 16'hFFFF, 15'h0010, 0, 15'h0, 16'h0, 3, 6'b001100};
    v[10] = '{16'h0000, 16'h0000, 16'h0010, 16'hE302, 16'h0000, 0, 0, 16'h0010, 16'h0000, 15'h0010, 0, 15'h0, 16'h0, 3, 6'b001100};
    v[11] = '{16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h0000, 2, 0, 16'h0005, 16'h0000, 15'h0004, 0, 15'h0, 16'h0, 4, 6'b000000};
    load(16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    do_reset("init");
    tick();
    chk("first_req", s_req, 1);
    chk("first_addr", s_addr, 0);
    chk("first_re", s_re, 0);
    chk("first_a", s_a, 0);
    chk("first_d", s_d, 0);
    tick();
    tick();
    chk("at5_a", s_a, 16'h0005);
    chk("at5_pc", s_pc, 1);
    chk("at5_req", s_req, 1);
    chk("at5_we", wr_cnt, 0);
    for (int i = 0; i < 12; i++) begin
      t = $sformatf("v%0d", i);
      load(v[i].p0, v[i].p1, v[i].p2, v[i].p3, v[i].m3, v[i].rw, v[i].mw);
      do_reset(t);
      run(4, cyc, ok);
      chk({t, "_done"}, ok, 1);
      chk({t, "_a"}, s_a, v[i].ea);
      chk({t, "_d"}, s_d, v[i].ed);
      chk({t, "_pc"}, s_pc, v[i].epc);
      chk({t, "_cycles"}, cyc, v[i].ecyc);
      chk({t, "_writes"}, wr_cnt, v[i].ewr);
      if (v[i].ewr > 0) begin
        chk({t, "_waddr"}, wr_addr, v[i].waddr);
        chk({t, "_wdata"}, wr_data, v[i].wdata);
      end
      if (v[i].p3[15]) chk({t, "_ctrl"}, ex_ctrl, v[i].ectrl);
    end
    load(16'h0000, 16'h0000, 16'h0003, 16'hFCA8, 16'h0001, 0, 50);
    do_reset("rdrst");
    n = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (s_re) n++;
      if (n == 3) break;
    end
    chk("rdrst_in_read", n, 3);
    reset = 1'b1;
    tick();
    chk("rdrst_re", s_re, 0);
    chk("rdrst_we", s_we, 0);
    reset = 1'b0;
    tick();
    chk("rdrst_req", s_req, 1);
    chk("rdrst_addr", s_addr, 0);
    chk("rdrst_pc", s_pc, 0);
    for (int k = 0; k < 4; k++) tick();
    chk("rdrst_nowrite", wr_cnt, 0);
    load(16'h7FFF, 16'hEA87, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    rom[31] = 16'h0007;
    do_reset("wrap");
    run(3, cyc, ok);
    chk("wrap_done", ok, 1);
    chk("wrap_fetch_addr", hs_addr, 15'h7FFF);
    chk("wrap_pc", s_pc, 0);
    chk("wrap_addr", s_addr, 0);
    chk("wrap_a", s_a, 16'h0007);
    chk("wrap_cycles", cyc, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
